// File: rtl/mem_arbiter.sv
// Two-master (debug/CPU) arbiter for a single 32-bit memory port,
// with round-robin or debug-priority grant and an access watchdog.
module mem_arbiter #(
   parameter logic        DBG_PRIORITY = 1'b0,
   parameter int unsigned TIMEOUT      = 1024,
   parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [31:0] dbg_adr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   input  logic        dbg_RW,
   input  logic        dbg_op,
   output logic        dbg_rdy,
   input  logic [31:0] cpu_adr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   input  logic        cpu_RW,
   input  logic        cpu_op,
   output logic        cpu_rdy,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic        mem_RW,
   output logic        mem_op,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdy,
   output logic        gnt_dbg,
   output logic        gnt_cpu,
   output logic        err,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G_DBG = 2'd1,
      G_CPU = 2'd2
   } state_t;

   localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  ecnt_q, ecnt_d;

   logic        x_op;
   logic        x_rdy;
   logic        tmo;
   logic [31:0] x_rdata;
   logic        pick_dbg;

   // last_q = 1 means the CPU was granted most recently
   assign pick_dbg = DBG_PRIORITY | last_q;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      mem_adr   = 32'h0;
      mem_wdata = 32'h0;
      mem_RW    = 1'b1;
      mem_op    = 1'b0;
      dbg_rdy   = 1'b0;
      cpu_rdy   = 1'b0;
      dbg_rdata = 32'h0;
      cpu_rdata = 32'h0;
      gnt_dbg   = 1'b0;
      gnt_cpu   = 1'b0;
      x_op      = 1'b0;
      tmo       = 1'b0;
      x_rdy     = 1'b0;
      x_rdata   = 32'h0;
      unique case (state_q)
         IDLE: begin
            cnt_d = 16'h0;
            if (dbg_op && (!cpu_op || pick_dbg)) begin
               state_d = G_DBG;
               last_d  = 1'b0;
            end else if (cpu_op) begin
               state_d = G_CPU;
               last_d  = 1'b1;
            end
         end
         G_DBG, G_CPU: begin
            if (state_q == G_DBG) begin
               mem_adr   = dbg_adr;
               mem_wdata = dbg_wdata;
               mem_RW    = dbg_RW;
               x_op      = dbg_op;
               gnt_dbg   = 1'b1;
            end else begin
               mem_adr   = cpu_adr;
               mem_wdata = cpu_wdata;
               mem_RW    = cpu_RW;
               x_op      = cpu_op;
               gnt_cpu   = 1'b1;
            end
            mem_op  = x_op;
            // memory completion outranks the watchdog on the same cycle
            tmo     = x_op && !mem_rdy && (cnt_q == T_LAST);
            x_rdy   = mem_rdy | tmo;
            x_rdata = tmo ? ERR_DATA : mem_rdata;
            if (state_q == G_DBG) begin
               dbg_rdy   = x_rdy;
               dbg_rdata = x_rdata;
            end else begin
               cpu_rdy   = x_rdy;
               cpu_rdata = x_rdata;
            end
            if (mem_rdy || !x_op || tmo) begin
               state_d = IDLE;
               cnt_d   = 16'h0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'h0;
         end
      endcase
   end

   assign err = tmo;

   // count is visible in the timeout cycle itself
   always_comb begin
      err_count = ecnt_q;
      if (tmo && ecnt_q != 8'hFF)
         err_count = ecnt_q + 8'd1;
      ecnt_d = err_count;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 16'h0;
         ecnt_q  <= 8'h0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ecnt_q  <= ecnt_d;
      end
   end

endmodule
